// File: rtl/tt_capture7_if.sv
// Signal bundle between tt_capture7 and the function block / controller.
// Optional self_dual member present when SELF_DUAL_CHECK_EN is defined.
interface tt_capture7_if;
    logic         start;
    logic         f_in;
    logic         x0, x1, x2, x3, x4, x5, x6;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic [7:0]   ones_count;
`ifdef SELF_DUAL_CHECK_EN
    logic         self_dual;
`endif

    modport master (
        input  start, f_in,
        output x0, x1, x2, x3, x4, x5, x6,
`ifdef SELF_DUAL_CHECK_EN
        output self_dual,
`endif
        output busy, done, tt, ones_count
    );

    modport slave (
        output start, f_in,
        input  x0, x1, x2, x3, x4, x5, x6,
`ifdef SELF_DUAL_CHECK_EN
        input  self_dual,
`endif
        input  busy, done, tt, ones_count
    );
endinterface

// File: rtl/tt_capture7.sv
// Truth-table extractor for a 7-input combinational block: sweeps all 128 vectors.
// Optional macro SELF_DUAL_CHECK_EN adds the self_dual result output.
module tt_capture7 #(
    parameter int unsigned SETTLE = 0
) (
    input  logic           clk,
    input  logic           rst,
    tt_capture7_if.master  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t       state, state_next;
    logic [6:0]   idx;
    logic [3:0]   wait_cnt;
    logic [127:0] tt_q;
    logic [7:0]   ones_q;
    logic         busy_q, done_q;
    logic         accept, sample, last;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wait_cnt == SETTLE_L) begin
                    sample = 1'b1;
                    if (idx == 7'd127) begin
                        last       = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

`ifdef SELF_DUAL_CHECK_EN
    logic [127:0] tt_final;
    logic         dual_next;
    logic         self_dual_q;

    // The last sample is not yet in tt_q when the verdict is registered.
    always_comb begin
        tt_final      = tt_q;
        tt_final[127] = bus.f_in;
        dual_next     = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (tt_final[i] == tt_final[127-i]) dual_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 self_dual_q <= 1'b0;
        else if (accept)         self_dual_q <= 1'b0;
        else if (sample && last) self_dual_q <= dual_next;
    end

    assign bus.self_dual = self_dual_q;
`endif

    // idx returns to 0 on completion so the vector outputs idle low in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 7'd0;
            wait_cnt <= 4'd0;
            tt_q     <= '0;
            ones_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx      <= 7'd0;
                wait_cnt <= 4'd0;
                tt_q     <= '0;
                ones_q   <= 8'd0;
                busy_q   <= 1'b1;
            end else if (state == ST_RUN) begin
                if (sample) begin
                    tt_q[idx] <= bus.f_in;
                    ones_q    <= ones_q + {7'd0, bus.f_in};
                    wait_cnt  <= 4'd0;
                    if (last) begin
                        idx    <= 7'd0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + 7'd1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.x0         = idx[0];
    assign bus.x1         = idx[1];
    assign bus.x2         = idx[2];
    assign bus.x3         = idx[3];
    assign bus.x4         = idx[4];
    assign bus.x5         = idx[5];
    assign bus.x6         = idx[6];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.tt         = tt_q;
    assign bus.ones_count = ones_q;

endmodule
